// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 1 so an idle-high serial line reads as idle straight out of reset.
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, start-bit glitch rejection,
// break detection, one-cycle valid/break strobes.
module uart_rx #(
   parameter int BIT_RATE     = 115200,
   parameter int CLK_HZ       = 50000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_break,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam int IW = $clog2(PAYLOAD_BITS + 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CYCLES_PER_BIT / 2);
   localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES_PER_BIT - 1);
   localparam logic [IW-1:0] NBITS    = IW'(PAYLOAD_BITS);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [PAYLOAD_BITS-1:0] sh, sh_nxt;
   logic [PAYLOAD_BITS-1:0] data_nxt;
   logic                    valid_nxt, brk_nxt;
   logic                    rxd_s;

   sync_2ff u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (uart_rxd),
      .q      (rxd_s)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         sh            <= '0;
         uart_rx_data  <= '0;
         uart_rx_valid <= 1'b0;
         uart_rx_break <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         idx           <= idx_nxt;
         sh            <= sh_nxt;
         uart_rx_data  <= data_nxt;
         uart_rx_valid <= valid_nxt;
         uart_rx_break <= brk_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      sh_nxt    = sh;
      data_nxt  = uart_rx_data;
      valid_nxt = 1'b0;
      brk_nxt   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rxd_s) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_BIT) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            // Counter keeps running through the load cycle so the stop
            // sample still lands one full bit after the last data sample.
            if (idx == NBITS) begin
               data_nxt  = sh;
               state_nxt = STOP;
            end else if (cnt == LAST_CYC) begin
               cnt_nxt = '0;
               sh_nxt  = PAYLOAD_BITS'({rxd_s, sh} >> 1);
               idx_nxt = idx + 1'b1;
            end
         end
         STOP: begin
            if (cnt == LAST_CYC) begin
               state_nxt = IDLE;
               valid_nxt = rxd_s;
               brk_nxt   = !rxd_s && (sh == '0);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!uart_rx_en) begin
         state_nxt = IDLE;
         data_nxt  = uart_rx_data;
         valid_nxt = 1'b0;
         brk_nxt   = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a frame-level model predicts
// each pulse and the held byte; a monitor pops and compares on every strobe.
module tb_uart_rx;

   localparam int BIT_NS = 8680;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       uart_rx_en = 1'b0;
   logic       uart_rx_break, uart_rx_valid;
   logic [7:0] uart_rx_data;

   // 25 MHz keeps 8680 ns at exactly 217 cycles per bit with half the sim time.
   uart_rx #(
      .BIT_RATE     (115200),
      .CLK_HZ       (25000000),
      .PAYLOAD_BITS (8),
      .STOP_BITS    (1)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .uart_rxd      (uart_rxd),
      .uart_rx_en    (uart_rx_en),
      .uart_rx_break (uart_rx_break),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data)
   );

   always #20 clk = ~clk;

   typedef struct {
      bit         brk;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   int         checks = 0, errors = 0, nvalid = 0, nbrk = 0;
   logic [7:0] exp_data = 8'h00;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: an enabled frame always updates the held byte; the
   // stop bit and byte value decide which strobe (if any) follows.
   task automatic send(input logic [7:0] b, input bit stop_v, input bit rx);
      uart_rxd = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         #BIT_NS;
      end
      uart_rxd = stop_v;
      if (rx) begin
         exp_data = b;
         if (stop_v) exp_q.push_back('{1'b0, b});
         else if (b == 8'h00) exp_q.push_back('{1'b1, b});
      end
      #1000;
      chk("data_in_stop", int'(uart_rx_data), int'(exp_data));
      if (!stop_v) begin
         // Release a low stop bit early so the line's return is not itself
         // taken as a fresh start bit.
         #(BIT_NS * 3 / 4 - 1000);
         uart_rxd = 1'b1;
         #(BIT_NS / 4);
      end else begin
         #(BIT_NS - 1000);
      end
      uart_rxd = 1'b1;
   endtask

   always @(negedge clk) begin
      if (resetn && (uart_rx_valid || uart_rx_break)) begin
         if (uart_rx_valid) nvalid++;
         if (uart_rx_break) nbrk++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'({uart_rx_valid, uart_rx_break}), 0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("pulse_kind", int'({uart_rx_valid, uart_rx_break}), int'({!e.brk, e.brk}));
            chk("rx_byte", int'(uart_rx_data), int'(e.data));
         end
      end
   end

   initial begin
      int v0, b0;
      logic [7:0] b;

      #55;
      chk("rst_data", int'(uart_rx_data), 0);
      chk("rst_valid", int'(uart_rx_valid), 0);
      chk("rst_break", int'(uart_rx_break), 0);
      resetn = 1'b1;
      uart_rx_en = 1'b1;
      #BIT_NS;

      v0 = nvalid;
      send(8'h24, 1'b1, 1'b1);
      #BIT_NS;
      chk("first_valid_cnt", nvalid - v0, 1);
      chk("first_no_break", nbrk, 0);

      v0 = nvalid;
      repeat (10) begin
         b = 8'($urandom);
         send(b, 1'b1, 1'b1);
         #BIT_NS;
      end
      chk("ten_valid_cnt", nvalid - v0, 10);

      v0 = nvalid;
      send(8'($urandom), 1'b1, 1'b1);
      send(8'($urandom), 1'b1, 1'b1);
      #BIT_NS;
      chk("b2b_valid_cnt", nvalid - v0, 2);

      v0 = nvalid;
      b0 = nbrk;
      send(8'h00, 1'b0, 1'b1);
      #(BIT_NS * 2);
      chk("break_cnt", nbrk - b0, 1);
      chk("break_no_valid", nvalid - v0, 0);

      v0 = nvalid;
      b0 = nbrk;
      send(8'h3C, 1'b0, 1'b1);
      #(BIT_NS * 2);
      chk("framing_no_pulse", (nvalid - v0) + (nbrk - b0), 0);

      v0 = nvalid;
      uart_rxd = 1'b0;
      #2000;
      uart_rxd = 1'b1;
      #(BIT_NS * 2);
      chk("glitch_no_pulse", nvalid - v0, 0);
      chk("glitch_data_held", int'(uart_rx_data), int'(exp_data));

      v0 = nvalid;
      uart_rx_en = 1'b0;
      send(8'h5A, 1'b1, 1'b0);
      #BIT_NS;
      chk("disabled_no_pulse", nvalid - v0, 0);
      uart_rx_en = 1'b1;
      #BIT_NS;
      send(8'hA5, 1'b1, 1'b1);
      #BIT_NS;
      chk("enabled_valid_cnt", nvalid - v0, 1);

      v0 = nvalid;
      b0 = nbrk;
      fork
         send(8'h33, 1'b1, 1'b0);
         begin
            #(BIT_NS * 4);
            resetn = 1'b0;
            exp_data = 8'h00;
            #100;
            chk("midrst_data", int'(uart_rx_data), 0);
            chk("midrst_strobes", int'({uart_rx_valid, uart_rx_break}), 0);
         end
      join
      resetn = 1'b1;
      #BIT_NS;
      chk("midrst_no_pulse", (nvalid - v0) + (nbrk - b0), 0);
      send(8'h81, 1'b1, 1'b1);
      #(BIT_NS * 2);
      chk("post_rst_valid_cnt", nvalid - v0, 1);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
